// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared FSM state and error codes for the ccff chain loader
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PROBE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - holds one host word and hands its bits out LSB first
module ccff_word_serializer #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    input  logic [CNT_W-1:0]  avail,
    output logic              next_bit,
    output logic              last
);
    localparam logic [31:0] WORD_W32 = WORD_W;

    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  rem;

    // Bit 0 leaves via ccff_head at load time, so only the remaining bits are kept;
    // rem is clipped to the room left in the chain so a final word can be partial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            rem    <= '0;
        end else if (load) begin
            word_q <= word >> 1;
            rem    <= (32'(avail) < WORD_W32) ? avail : WORD_W32[CNT_W-1:0];
        end else if (shift) begin
            word_q <= word_q >> 1;
            rem    <= rem - CNT_W'(1);
        end
    end

    assign next_bit = word_q[0];
    assign last     = (rem == CNT_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - programs one ccff shift chain with optional length check
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(2 * CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              check_en,
    input  logic              abort,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  bits_loaded
);
    localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN2 = CNT_W'(2 * CHAIN_LEN);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ser_next;
    logic             ser_last;

    // A word offered in the same cycle as abort is refused.
    assign cfg_ready = (state == ST_LOAD) && !abort;

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_ser (
        .clk      (prog_clk),
        .rst_n    (pReset),
        .load     (cfg_ready && cfg_valid),
        .shift    (state == ST_SHIFT),
        .word     (cfg_data),
        .avail    (LEN - bits_loaded),
        .next_bit (ser_next),
        .last     (ser_last)
    );

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ccff_head   <= 1'b0;
            ccff_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            bits_loaded <= '0;
        end else if (busy && abort) begin
            state     <= ST_ERR;
            ccff_en   <= 1'b0;
            ccff_head <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_code  <= ERR_ABORT;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        err_code    <= ERR_NONE;
                        bits_loaded <= '0;
                        cnt         <= '0;
                        ccff_head   <= 1'b0;
                        ccff_en     <= check_en;
                        state       <= check_en ? ST_CLEAR : ST_LOAD;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LEN - CNT_W'(1)) begin
                        state     <= ST_PROBE;
                        cnt       <= '0;
                        ccff_head <= 1'b1;
                    end
                end
                // cnt is the number of probe shifts already taken by the chain
                ST_PROBE: begin
                    ccff_head <= 1'b0;
                    if (ccff_tail) begin
                        ccff_en <= 1'b0;
                        if (cnt == LEN) begin
                            state <= ST_LOAD;
                        end else begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_LEN;
                        end
                    end else if (cnt == LEN2) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        ccff_en <= (cnt != LEN2 - CNT_W'(1));
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        state     <= ST_SHIFT;
                        ccff_en   <= 1'b1;
                        ccff_head <= cfg_data[0];
                    end
                end
                ST_SHIFT: begin
                    bits_loaded <= bits_loaded + CNT_W'(1);
                    if (ser_last) begin
                        ccff_en   <= 1'b0;
                        ccff_head <= 1'b0;
                        if (bits_loaded == LEN - CNT_W'(1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end else begin
                        ccff_head <= ser_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
